// File: rtl/hilo_mult_ctrl.sv
// hilo_mult_ctrl: HI/LO register file and sequencer for an external iterative
// unsigned multiplier. Signed MULT operands are reduced to magnitudes before
// launch and the 64-bit product is sign-corrected before it lands in HI/LO.
module hilo_mult_ctrl #(
    parameter int TIMEOUT = 128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_valid,
    input  logic [1:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        op_ready,
    output logic        busy,
    input  logic        mf_req,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        err,
    output logic        mul_valid_in,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_valid_out,
    input  logic [63:0] mul_r
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LAUNCH = 2'b01,
        S_WAIT   = 2'b10,
        S_FIX    = 2'b11
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [31:0]  r_hi;
    logic [31:0]  r_lo;
    logic         r_err;
    logic         r_busy;
    logic         r_mul_valid_in;
    logic [31:0]  r_mul_a;
    logic [31:0]  r_mul_b;
    logic         r_neg;
    logic [63:0]  r_prod;
    logic [CW-1:0] r_cnt;
    logic         w_accept;
    logic         w_capture;
    logic         w_timeout;

    // Two's-complement magnitude; the most negative value maps onto itself,
    // which is exactly right when read back as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] x);
        mag32 = x[31] ? (~x + 32'd1) : x;
    endfunction

    // Conditional 64-bit negation used for the final sign correction.
    function automatic logic [63:0] cneg64(input logic neg, input logic [63:0] x);
        cneg64 = neg ? (~x + 64'd1) : x;
    endfunction

    assign op_ready     = ~r_busy;
    assign busy         = r_busy;
    assign stall        = mf_req & r_busy;
    assign hi           = r_hi;
    assign lo           = r_lo;
    assign err          = r_err;
    assign mul_valid_in = r_mul_valid_in;
    assign mul_a        = r_mul_a;
    assign mul_b        = r_mul_b;

    assign w_accept = op_valid & (r_state == S_IDLE);

    // Next-state decode; also flags product capture and WAIT timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (op[1] == 1'b0)) begin
                    w_state_nxt = S_LAUNCH;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LAUNCH: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mul_valid_out) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_FIX;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register plus registered busy / start-pulse outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
            r_mul_valid_in <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_busy         <= (w_state_nxt != S_IDLE);
            r_mul_valid_in <= (w_state_nxt == S_LAUNCH);
        end
    end

    // Operand latching at acceptance; held stable until the next multiply.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mul_a <= 32'd0;
            r_mul_b <= 32'd0;
            r_neg   <= 1'b0;
        end else if (w_accept && (op == OP_MULT)) begin
            r_mul_a <= mag32(rs);
            r_mul_b <= mag32(rt);
            r_neg   <= rs[31] ^ rt[31];
        end else if (w_accept && (op == OP_MULTU)) begin
            r_mul_a <= rs;
            r_mul_b <= rt;
            r_neg   <= 1'b0;
        end else begin
            r_mul_a <= r_mul_a;
            r_mul_b <= r_mul_b;
            r_neg   <= r_neg;
        end
    end

    // WAIT cycle counter and raw product capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_prod <= 64'd0;
        end else begin
            if (r_state == S_LAUNCH) begin
                r_cnt <= '0;
            end else if ((r_state == S_WAIT) && !w_capture && !w_timeout) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= r_cnt;
            end
            if (w_capture) begin
                r_prod <= mul_r;
            end else begin
                r_prod <= r_prod;
            end
        end
    end

    // Architectural HI/LO: direct moves in IDLE, sign-corrected product in FIX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (r_state == S_FIX) begin
            {r_hi, r_lo} <= cneg64(r_neg, r_prod);
        end else if (w_accept && (op == OP_MTHI)) begin
            r_hi <= rs;
        end else if (w_accept && (op == OP_MTLO)) begin
            r_lo <= rs;
        end else begin
            r_hi <= r_hi;
            r_lo <= r_lo;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Self-checking bench for hilo_mult_ctrl: directed and random multiplies,
// HI/LO moves, stall/hold-off, timeout and asynchronous reset mid-operation.
module tb_hilo_mult_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs = 32'd0;
    logic [31:0] rt = 32'd0;
    logic        mf_req = 1'b0;
    logic        mul_valid_out = 1'b0;
    logic [63:0] mul_r = 64'd0;
    logic        op_ready, busy, stall, err, mul_valid_in;
    logic [31:0] hi, lo, mul_a, mul_b;

    int total = 0;
    int bad = 0;

    // reference architectural state
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        m_err = 1'b0;

    always #5 clk = ~clk;

    hilo_mult_ctrl #(.TIMEOUT(128)) dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op),
        .rs(rs), .rt(rt), .op_ready(op_ready), .busy(busy), .mf_req(mf_req),
        .stall(stall), .hi(hi), .lo(lo), .err(err), .mul_valid_in(mul_valid_in),
        .mul_a(mul_a), .mul_b(mul_b), .mul_valid_out(mul_valid_out), .mul_r(mul_r)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_move(input logic is_hi, input logic [31:0] v);
        op_valid = 1'b1;
        op       = is_hi ? 2'b10 : 2'b11;
        rs       = v;
        chk("mv_ready", op_ready, 1'b1);
        step();
        op_valid = 1'b0;
        if (is_hi) m_hi = v; else m_lo = v;
        chk("mv_busy", busy, 1'b0);
        chk("mv_hi", hi, m_hi);
        chk("mv_lo", lo, m_lo);
    endtask

    // One multiply with a multiplier that answers after dly idle WAIT cycles.
    task automatic do_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int dly, input logic mf, input logic pend);
        logic [31:0] ea, eb, pv;
        logic [63:0] res;
        longint      sa, sb;
        ea = (sgn && a[31]) ? -a : a;
        eb = (sgn && b[31]) ? -b : b;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            res = sa * sb;
        end else begin
            res = {32'd0, a} * {32'd0, b};
        end
        pv = a ^ 32'h5A5A_5A5A;
        mf_req   = mf;
        op_valid = 1'b1;
        op       = sgn ? 2'b00 : 2'b01;
        rs       = a;
        rt       = b;
        chk("idle_ready", op_ready, 1'b1);
        chk("idle_stall", stall, 1'b0);
        step();                                  // LAUNCH
        if (pend) begin
            op = 2'b10;
            rs = pv;
        end else begin
            op_valid = 1'b0;
        end
        chk("l_mvi", mul_valid_in, 1'b1);
        chk("l_mul_a", mul_a, ea);
        chk("l_mul_b", mul_b, eb);
        chk("l_busy", busy, 1'b1);
        chk("l_ready", op_ready, 1'b0);
        chk("l_stall", stall, mf);
        step();                                  // WAIT
        chk("w_mvi", mul_valid_in, 1'b0);
        chk("w_busy", busy, 1'b1);
        chk("w_stall", stall, mf);
        for (int i = 0; i < dly; i++) begin
            step();
            chk("w_hold_a", mul_a, ea);
            chk("w_busy2", busy, 1'b1);
        end
        mul_valid_out = 1'b1;
        mul_r         = {32'd0, ea} * {32'd0, eb};
        step();                                  // FIX
        mul_valid_out = 1'b0;
        mul_r         = {$urandom, $urandom};
        chk("f_busy", busy, 1'b1);
        chk("f_stall", stall, mf);
        chk("f_ready", op_ready, 1'b0);
        chk("f_hi_old", hi, m_hi);
        step();                                  // IDLE, result visible
        m_hi = res[63:32];
        m_lo = res[31:0];
        chk("r_busy", busy, 1'b0);
        chk("r_ready", op_ready, 1'b1);
        chk("r_stall", stall, 1'b0);
        chk("r_hi", hi, m_hi);
        chk("r_lo", lo, m_lo);
        chk("r_err", err, m_err);
        if (pend) begin
            step();                              // held MTHI accepted now
            op_valid = 1'b0;
            m_hi = pv;
            chk("p_hi", hi, m_hi);
            chk("p_lo", lo, m_lo);
            chk("p_busy", busy, 1'b0);
        end
        mf_req = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mvi", mul_valid_in, 1'b0);
        chk("rst_a", mul_a, 32'd0);
        chk("rst_b", mul_b, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // directed cases
        do_mul(1'b0, 32'd7, 32'd9, 2, 1'b0, 1'b0);
        chk("d_7x9_lo", lo, 32'd63);
        do_mul(1'b1, 32'hFFFF_FFFE, 32'd3, 0, 1'b0, 1'b0);
        chk("d_m2x3_hi", hi, 32'hFFFF_FFFF);
        chk("d_m2x3_lo", lo, 32'hFFFF_FFFA);
        do_mul(1'b1, 32'h8000_0000, 32'h8000_0000, 1, 1'b0, 1'b0);
        chk("d_min_hi", hi, 32'h4000_0000);
        do_mul(1'b0, 32'h8000_0000, 32'h8000_0000, 3, 1'b0, 1'b0);
        chk("d_minu_hi", hi, 32'h4000_0000);
        chk("d_minu_lo", lo, 32'd0);
        do_move(1'b1, 32'h1234_5678);
        do_move(1'b0, 32'h9ABC_DEF0);
        do_mul(1'b1, 32'd5, 32'hFFFF_FFF9, 4, 1'b1, 1'b1);

        // mul_valid_out in IDLE is ignored
        mul_valid_out = 1'b1;
        mul_r = 64'hDEAD_BEEF_CAFE_F00D;
        step();
        mul_valid_out = 1'b0;
        chk("idle_ign_hi", hi, m_hi);
        chk("idle_ign_busy", busy, 1'b0);

        // random multiplies and moves
        for (int n = 0; n < 30; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if (n % 5 == 0) a = $urandom_range(0, 20);
            if (n % 7 == 0) b = 32'h8000_0000;
            if (n % 6 == 3) do_move($urandom_range(0, 1), $urandom);
            do_mul($urandom_range(0, 1), a, b, $urandom_range(0, 6),
                   $urandom_range(0, 1), $urandom_range(0, 1));
        end

        // timeout: multiplier stays silent
        op_valid = 1'b1; op = 2'b00; rs = $urandom; rt = $urandom;
        step();                                  // LAUNCH
        op_valid = 1'b0;
        repeat (128) step();
        chk("to_err_early", err, 1'b0);
        chk("to_busy_early", busy, 1'b1);
        step();
        m_err = 1'b1;
        chk("to_err", err, 1'b1);
        chk("to_busy", busy, 1'b0);
        chk("to_hi", hi, m_hi);
        chk("to_lo", lo, m_lo);
        do_mul(1'b0, 32'd11, 32'd13, 1, 1'b0, 1'b0);
        chk("to_sticky", err, 1'b1);

        // asynchronous reset mid-WAIT
        do_move(1'b1, 32'hA5A5_0001);
        op_valid = 1'b1; op = 2'b01; rs = 32'd100; rt = 32'd200;
        step();
        op_valid = 1'b0;
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        m_hi = 32'd0; m_lo = 32'd0; m_err = 1'b0;
        chk("ar_hi", hi, 32'd0);
        chk("ar_lo", lo, 32'd0);
        chk("ar_busy", busy, 1'b0);
        chk("ar_mvi", mul_valid_in, 1'b0);
        chk("ar_err", err, 1'b0);
        chk("ar_ready", op_ready, 1'b1);
        @(negedge clk);
        mul_valid_out = 1'b1;
        mul_r = 64'd20000;
        reset_n = 1'b1;
        step();
        mul_valid_out = 1'b0;
        chk("ar_abandon_lo", lo, 32'd0);
        chk("ar_abandon_busy", busy, 1'b0);
        do_mul(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
